sample_frame_router: RTL
========================

Name: sample_frame_router

Overview:
- Parses the byte stream from the FT245 simple-interface RX side (valid/ready) into framed sample packets.
- Assembles multi-byte samples and routes them to one of NUM_CH modulator channels; each channel output uses valid/ready.
- Latches a per-channel mode nibble from the frame header, so each channel can switch AM/PSK without a rebuild.
- Sits between the ft245 wrapper and the per-channel sample FIFOs; replaces the fixed single FIFO feed.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- SAMPLE_BYTES, 1, bytes per sample (1..4), little-endian; SW = 8*SAMPLE_BYTES.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, maximum idle gap between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock (128 MHz domain)
- rst  in  1  reset, synchronous, active-high
- in_data  in  8  RX byte from simple interface
- in_valid  in  1  byte available
- in_ready  out  1  byte accepted when in_valid & in_ready
- ch_data  out  NUM_CH*SW  per-channel sample; channel k occupies bits [k*SW +: SW]
- ch_valid  out  NUM_CH  per-channel sample valid (one-hot or zero)
- ch_ready  in  NUM_CH  per-channel accept (e.g. !fifo_full)
- ch_mode  out  NUM_CH*4  per-channel mode nibble, latched from header
- frame_done  out  1  one-cycle pulse after the last payload sample is handed off
- sync_err_cnt  out  8  saturating count of bytes discarded while hunting
- ch_err_cnt  out  8  saturating count of frames with channel id >= NUM_CH
- timeout_cnt  out  8  saturating count of aborted frames

Behaviour:
- Frame format: SYNC, HDR (hdr[3:0] = channel id, hdr[7:4] = mode), LEN (sample count minus 1, so 1..256 samples), then (LEN+1)*SAMPLE_BYTES payload bytes.
- Reset: state HUNT; all ch_valid = 0, ch_data = 0, ch_mode = 0, counters = 0, frame_done = 0, in_ready = 1.
- States: HUNT, HDR, LEN, PAYLOAD, DISCARD.
- HUNT: accepts a byte every cycle. If byte == SYNC_BYTE, go to HDR. Otherwise increment sync_err_cnt (saturates at 255).
- HDR: on accept, capture the channel id.
  - If id < NUM_CH: ch_mode[id] <= hdr[7:4], effective the next cycle.
  - If id >= NUM_CH: increment ch_err_cnt; mark the frame as discard.
  - Then go to LEN.
- LEN: capture the sample count. Go to PAYLOAD for a valid channel, DISCARD otherwise.
- PAYLOAD:
  - Bytes shift into the packer, LSB byte first.
  - On the byte that completes a sample, the hold register loads; ch_valid[cur_ch] rises the next cycle.
  - in_ready = !hold_valid | ch_ready[cur_ch] (zero-bubble throughput).
  - The hold register clears when ch_ready[cur_ch] is high.
  - After the final sample completes, go to HUNT. frame_done pulses in the cycle that final sample's ch_valid & ch_ready handshake occurs.
- DISCARD: in_ready = 1. Consume (LEN+1)*SAMPLE_BYTES bytes, produce no output, then go to HUNT.
- Timeout: in HDR, LEN, PAYLOAD or DISCARD, an idle counter counts cycles without an accepted byte. While a sample is held with ch_ready low, the counter is frozen; downstream stall is not a timeout.
  - At TIMEOUT_CYCLES the frame aborts: go to HUNT, increment timeout_cnt, drop any partially packed bytes.
  - A sample already in the hold register is still delivered.
- Simultaneous events:
  - Hold drain and new sample completion in the same cycle: the hold reloads, ch_valid stays high.
  - A SYNC_BYTE value inside the payload is treated as data, not resync.
- ch_valid holds stable with constant ch_data until handshake (AXI-stream rules).
- Reset mid-frame: immediate return to reset state; the held sample is lost.

Decomposition:
- Shared package sample_router_pkg:
  - state enum;
  - SYNC_BYTE default;
  - counter width (8);
  - header field positions (ID_LSB = 0, MODE_LSB = 4).
- One sub-module, sample_packer (SAMPLE_BYTES parameter). It contains:
  - byte shift register and byte index counter;
  - hold register with valid/ready;
  - clear input for abort.
- The FSM, sample counter, timeout counter and error counters stay in the top module.

Test Plan:
- NUM_CH=4, SAMPLE_BYTES=1, all ready high. Send A5 21 02 10 20 30 → ch_valid[1] on 3 consecutive cycles with 10, 20, 30; ch_mode[1] = 2; one frame_done; in_ready always 1.
- SAMPLE_BYTES=2. Send A5 03 00 34 12 → ch_data[3] = 16'h1234, single valid; ch_mode[3] = 0.
- Send 00 FF A5 05 01 AA BB → sync_err_cnt = 2; ch_err_cnt = 1; no ch_valid; state back in HUNT; a following good frame routes correctly.
- ch_ready[0] low for 10 cycles during a 4-sample frame → in_ready drops; data held stable; no timeout; all 4 samples delivered in order after release.
- TIMEOUT_CYCLES=16. Send A5 00 03 11, then idle 20 cycles → sample 11 delivered; timeout_cnt = 1; next A5 starts a new frame.
- Assert rst mid-payload with a held sample → all outputs and counters zero the next cycle; a fresh frame works.

Source files
------------

// File: rtl/sample_router_pkg.sv
// Shared types and constants for the FT245 sample frame router.
package sample_router_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_DISCARD
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CNT_W         = 8;
  localparam int         ID_LSB        = 0;
  localparam int         MODE_LSB      = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sample_frame_router_packer.sv
// Little-endian byte-to-sample packer with a single-entry valid/ready hold stage.
module sample_packer
  import sample_router_pkg::*;
#(
  parameter int SAMPLE_BYTES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      byte_vld_i,
  input  logic [7:0]                byte_i,
  input  logic                      ready_i,
  output logic [8*SAMPLE_BYTES-1:0] data_o,
  output logic                      valid_o,
  output logic                      last_byte_o
);

  localparam int SW    = 8 * SAMPLE_BYTES;
  localparam int IDX_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SW-1:0]    sample_w, hold_q, hold_d;
  logic             vld_q, vld_d;

  assign last_byte_o = byte_vld_i & (idx_q == IDX_W'(SAMPLE_BYTES - 1));

  generate
    if (SAMPLE_BYTES == 1) begin : g_single
      assign sample_w = byte_i;
    end else begin : g_multi
      // Lower bytes of the sample in flight; the completing byte bypasses straight into the hold.
      logic [SW-9:0] sh_q;
      always_ff @(posedge clk) begin
        if (rst) sh_q <= '0;
        else if (byte_vld_i && !last_byte_o) sh_q[8*idx_q +: 8] <= byte_i;
      end
      assign sample_w = {byte_i, sh_q};
    end
  endgenerate

  always_comb begin
    idx_d = idx_q;
    if (clr_i)           idx_d = '0;
    else if (byte_vld_i) idx_d = last_byte_o ? '0 : idx_q + IDX_W'(1);
    vld_d  = (vld_q & ~ready_i) | last_byte_o;
    hold_d = last_byte_o ? sample_w : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      hold_q <= hold_d;
    end
  end

  assign data_o  = hold_q;
  assign valid_o = vld_q;

endmodule

// File: rtl/sample_frame_router.sv
// Frame parser: SYNC, HDR(id/mode), LEN, payload; routes packed samples to one of NUM_CH outputs.
module sample_frame_router
  import sample_router_pkg::*;
#(
  parameter int         NUM_CH         = 4,
  parameter int         SAMPLE_BYTES   = 1,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       in_data_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  output logic [NUM_CH*8*SAMPLE_BYTES-1:0] ch_data_o,
  output logic [NUM_CH-1:0]                ch_valid_o,
  input  logic [NUM_CH-1:0]                ch_ready_i,
  output logic [NUM_CH*4-1:0]              ch_mode_o,
  output logic                             frame_done_o,
  output logic [CNT_W-1:0]                 sync_err_cnt_o,
  output logic [CNT_W-1:0]                 ch_err_cnt_o,
  output logic [CNT_W-1:0]                 timeout_cnt_o
);

  localparam int SW     = 8 * SAMPLE_BYTES;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int REM_W  = 10;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                   state_q;
  logic [CH_W-1:0]          cur_ch_q, hold_ch_q;
  logic                     bad_q, hold_last_q;
  logic [REM_W-1:0]         rem_q;
  logic [IDLE_W-1:0]        idle_q;
  logic [NUM_CH-1:0][3:0]   mode_q;
  logic [CNT_W-1:0]         sync_err_q, ch_err_q, timeout_q;

  logic [SW-1:0] hold_data;
  logic          hold_vld, hold_rdy, stalled, last_byte;
  logic          accept, pay_byte, id_ok, timeout_hit;
  logic [3:0]    id;

  // The hold carries its own channel tag so a stalled sample keeps its route across the next header.
  assign hold_rdy    = ch_ready_i[hold_ch_q];
  assign stalled     = hold_vld & ~hold_rdy;
  assign in_ready_o  = (state_q == ST_PAYLOAD) ? ~stalled : 1'b1;
  assign accept      = in_valid_i & in_ready_o;
  assign pay_byte    = accept & (state_q == ST_PAYLOAD);
  assign id          = in_data_i[ID_LSB +: 4];
  assign id_ok       = {1'b0, id} < 5'(NUM_CH);
  assign timeout_hit = (state_q != ST_HUNT) & ~accept & ~stalled &
                       (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  sample_packer #(.SAMPLE_BYTES(SAMPLE_BYTES)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (timeout_hit),
    .byte_vld_i  (pay_byte),
    .byte_i      (in_data_i),
    .ready_i     (hold_rdy),
    .data_o      (hold_data),
    .valid_o     (hold_vld),
    .last_byte_o (last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      cur_ch_q    <= '0;
      hold_ch_q   <= '0;
      hold_last_q <= 1'b0;
      bad_q       <= 1'b0;
      rem_q       <= '0;
      idle_q      <= '0;
      mode_q      <= '0;
      sync_err_q  <= '0;
      ch_err_q    <= '0;
      timeout_q   <= '0;
    end else begin
      // Idle gap counter; a downstream stall freezes it rather than counting toward abort.
      if (state_q == ST_HUNT || accept || timeout_hit) idle_q <= '0;
      else if (!stalled)                              idle_q <= idle_q + IDLE_W'(1);

      if (last_byte) begin
        hold_ch_q   <= cur_ch_q;
        hold_last_q <= (rem_q == '0);
      end

      if (timeout_hit) begin
        state_q   <= ST_HUNT;
        timeout_q <= sat_inc(timeout_q);
      end else if (accept) begin
        unique case (state_q)
          ST_HUNT: begin
            if (in_data_i == SYNC_BYTE) state_q    <= ST_HDR;
            else                        sync_err_q <= sat_inc(sync_err_q);
          end
          ST_HDR: begin
            if (id_ok) begin
              mode_q[CH_W'(id)] <= in_data_i[MODE_LSB +: 4];
              cur_ch_q          <= CH_W'(id);
              bad_q             <= 1'b0;
            end else begin
              ch_err_q <= sat_inc(ch_err_q);
              bad_q    <= 1'b1;
            end
            state_q <= ST_LEN;
          end
          ST_LEN: begin
            // PAYLOAD counts samples, DISCARD counts raw bytes.
            if (bad_q) begin
              rem_q   <= REM_W'((int'(in_data_i) + 1) * SAMPLE_BYTES - 1);
              state_q <= ST_DISCARD;
            end else begin
              rem_q   <= REM_W'(in_data_i);
              state_q <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (last_byte) begin
              if (rem_q == '0) state_q <= ST_HUNT;
              else             rem_q   <= rem_q - REM_W'(1);
            end
          end
          ST_DISCARD: begin
            if (rem_q == '0) state_q <= ST_HUNT;
            else             rem_q   <= rem_q - REM_W'(1);
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  always_comb begin
    ch_valid_o = '0;
    ch_data_o  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (hold_vld && hold_ch_q == CH_W'(k)) begin
        ch_valid_o[k]          = 1'b1;
        ch_data_o[k*SW +: SW]  = hold_data;
      end
    end
  end

  assign frame_done_o   = hold_vld & hold_rdy & hold_last_q;
  assign ch_mode_o      = mode_q;
  assign sync_err_cnt_o = sync_err_q;
  assign ch_err_cnt_o   = ch_err_q;
  assign timeout_cnt_o  = timeout_q;

endmodule
